// File: rtl/keystream_arbiter_pkg.sv
// keystream_arbiter_pkg: FSM state, channel id and default watchdog limit shared by the keystream arbiter
package keystream_arbiter_pkg;
  typedef enum logic [2:0] {KA_IDLE, KA_ISSUE, KA_WAIT, KA_DELIVER, KA_RESYNC} ks_arb_state_t;
  typedef enum logic {KS_CH_A, KS_CH_B} ks_channel_t;
  localparam int KS_ARB_DEFAULT_TIMEOUT = 64;
endpackage

// File: rtl/ks_watchdog_timer.sv
// ks_watchdog_timer: saturating cycle counter (clk, nrst, clr, en) raising expire at TIMEOUT_CYCLES-1
module ks_watchdog_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) count <= '0;
    else if (clr) count <= '0;
    else if (en && count != LAST) count <= count + 1'b1;
  end
  assign expire = count == LAST;
endmodule

// File: rtl/keystream_arbiter.sv
// keystream_arbiter: round-robin share of one hash byte source between req_a/req_b with watchdog; drives request_hash_byte_pulse/reset_hash, returns byte_x/valid_x, busy, timeout_err
module keystream_arbiter
  import keystream_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = KS_ARB_DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       resync,
  output logic [7:0] byte_a,
  output logic       valid_a,
  output logic [7:0] byte_b,
  output logic       valid_b,
  output logic       busy,
  output logic       timeout_err,
  output logic       request_hash_byte_pulse,
  output logic       reset_hash,
  input  logic [7:0] hash_byte_in,
  input  logic       hash_byte_pulse_in
);
  ks_arb_state_t state, state_nx;
  ks_channel_t grant, grant_nx, last_grant;
  logic resync_pending, expire, got_byte;
  ks_watchdog_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdt (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (state == KA_ISSUE),
    .en     (state == KA_WAIT),
    .expire (expire)
  );
  assign got_byte = state == KA_WAIT && hash_byte_pulse_in;
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    case (state)
      KA_IDLE:
        if (resync_pending || resync) state_nx = KA_RESYNC;
        else if (req_a || req_b) begin
          state_nx = KA_ISSUE;
          grant_nx = (req_a && req_b) ? (last_grant == KS_CH_A ? KS_CH_B : KS_CH_A)
                                      : (req_a ? KS_CH_A : KS_CH_B);
        end
      KA_ISSUE:   state_nx = KA_WAIT;
      KA_WAIT:    state_nx = hash_byte_pulse_in ? KA_DELIVER : resync ? KA_RESYNC : expire ? KA_IDLE : KA_WAIT;
      KA_DELIVER: state_nx = KA_IDLE;
      default:    state_nx = KA_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state                   <= KA_IDLE;
      grant                   <= KS_CH_A;
      last_grant              <= KS_CH_B;
      resync_pending          <= 1'b0;
      byte_a                  <= '0;
      byte_b                  <= '0;
      valid_a                 <= 1'b0;
      valid_b                 <= 1'b0;
      busy                    <= 1'b0;
      timeout_err             <= 1'b0;
      request_hash_byte_pulse <= 1'b0;
      reset_hash              <= 1'b0;
    end else begin
      state                   <= state_nx;
      grant                   <= grant_nx;
      busy                    <= state_nx != KA_IDLE;
      request_hash_byte_pulse <= state_nx == KA_ISSUE;
      reset_hash              <= state_nx == KA_RESYNC;
      valid_a                 <= state_nx == KA_DELIVER && grant == KS_CH_A;
      valid_b                 <= state_nx == KA_DELIVER && grant == KS_CH_B;
      if (state == KA_DELIVER) last_grant <= grant;
      if (got_byte && grant == KS_CH_A) byte_a <= hash_byte_in;
      if (got_byte && grant == KS_CH_B) byte_b <= hash_byte_in;
      if (state == KA_RESYNC) timeout_err <= 1'b0;
      else if (state == KA_WAIT && state_nx == KA_IDLE) timeout_err <= 1'b1;
      // a resync that cannot be taken right now (including one beaten by a returning byte) is held for the next IDLE
      resync_pending <= state != KA_RESYNC &&
                        (resync_pending || (resync && (state == KA_ISSUE || state == KA_DELIVER || got_byte)));
    end
  end
endmodule
